// File: rtl/cache_line_fill_pkg.sv
// Shared types and constants for the L1 line-fill engine. Bus widths and MEM_READ normally come
// from the global defines; the fallbacks below only apply when the surrounding build has not set them.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 64
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 64
`endif
`ifndef BUS_TAG_WIDTH
`define BUS_TAG_WIDTH 4
`endif
`ifndef MEM_READ
`define MEM_READ 1
`endif

package cache_line_fill_pkg;
   localparam int unsigned ADDR_W     = `ADDRESS_SIZE;
   localparam int unsigned BUS_DW     = `BUS_DATA_WIDTH;
   localparam int unsigned TAG_W      = `BUS_TAG_WIDTH;
   localparam int unsigned BEATS      = 8;
   localparam int unsigned CELL_W     = 64;
   localparam int unsigned BEAT_CNT_W = $clog2(BEATS);

   localparam logic [TAG_W-1:0] MEM_READ_TAG     = TAG_W'(`MEM_READ);
   localparam logic [63:0]      LINE_OFFSET_MASK = 64'h3F;

   typedef logic [1:0] fill_state_t;
   localparam fill_state_t S_IDLE = 2'd0;
   localparam fill_state_t S_REQ  = 2'd1;
   localparam fill_state_t S_RESP = 2'd2;
   localparam fill_state_t S_DONE = 2'd3;

   // Same layout as the cache's cache_cells: cell n sits at bits [64n+63:64n].
   typedef logic [BEATS-1:0][CELL_W-1:0] cache_line_t;

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(LINE_OFFSET_MASK);
   endfunction
endpackage

// File: rtl/cache_line_fill_if.sv
// Cache-side and bus-side handshake bundle of the line-fill engine; master = engine, slave = cache + bus.
interface cache_line_fill_if
   import cache_line_fill_pkg::*;
   ;
   logic              miss_valid;
   logic              miss_ready;
   logic [ADDR_W-1:0] miss_addr;
   logic              miss_instr;
   logic              fill_valid;
   logic              fill_ready;
   logic [ADDR_W-1:0] fill_addr;
   logic              fill_instr;
   cache_line_t       fill_line;
   logic              fill_error;
   logic              bus_reqcyc;
   logic              bus_reqack;
   logic [BUS_DW-1:0] bus_req;
   logic [TAG_W-1:0]  bus_reqtag;
   logic              bus_respcyc;
   logic              bus_respack;
   logic [BUS_DW-1:0] bus_resp;
   logic [TAG_W-1:0]  bus_resptag;

   modport master (
      input  miss_valid, miss_addr, miss_instr, fill_ready,
      input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
      output miss_ready, fill_valid, fill_addr, fill_instr, fill_line, fill_error,
      output bus_reqcyc, bus_req, bus_reqtag, bus_respack
   );

   modport slave (
      output miss_valid, miss_addr, miss_instr, fill_ready,
      output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
      input  miss_ready, fill_valid, fill_addr, fill_instr, fill_line, fill_error,
      input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
   );
endinterface

// File: rtl/cache_line_fill_line_buffer.sv
// Beat collector: clr zeroes the line and counter, wr stores one cell at beat_cnt and advances it.
// full flags the write that completes the line (counter wraps 7 -> 0 on that same edge).
module fill_line_buffer
   import cache_line_fill_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              wr,
   input  logic [CELL_W-1:0] wdat,
   output cache_line_t       line,
   output logic              full
);
   cache_line_t           line_q, line_d;
   logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   always_comb begin
      line_d     = line_q;
      beat_cnt_d = beat_cnt_q;
      if (clr) begin
         line_d     = '0;
         beat_cnt_d = '0;
      end else if (wr) begin
         line_d[beat_cnt_q] = wdat;
         beat_cnt_d         = beat_cnt_q + BEAT_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         line_q     <= '0;
         beat_cnt_q <= '0;
      end else begin
         line_q     <= line_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign line = line_q;
   assign full = wr && (beat_cnt_q == BEAT_CNT_W'(BEATS - 1));
endmodule

// File: rtl/cache_line_fill.sv
// Single-outstanding L1 line fill: one aligned MEM_READ, eight beats into a 512-bit line, 10 cycles minimum.
// miss_ready only in IDLE; line held until fill_ready. CACHE_FILL_TIMEOUT_EN adds a REQ/RESP watchdog.
module cache_line_fill
   import cache_line_fill_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   cache_line_fill_if.master fill_if
);
   fill_state_t       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              instr_q, instr_d;
   logic              reqcyc_q, reqcyc_d;
   logic [BUS_DW-1:0] req_q, req_d;
   logic [TAG_W-1:0]  reqtag_q, reqtag_d;
   logic              respack_q, respack_d;
   logic              beat_ok, buf_clr, buf_full, timeout;
   cache_line_t       line;

   // Wrong-tag beats are still acked below but never reach the buffer.
   assign beat_ok = (state_q == S_RESP) && fill_if.bus_respcyc &&
                    (fill_if.bus_resptag == MEM_READ_TAG);

   fill_line_buffer u_line_buffer (
      .clk   (clk),
      .reset (reset),
      .clr   (buf_clr),
      .wr    (beat_ok),
      .wdat  (CELL_W'(fill_if.bus_resp)),
      .line  (line),
      .full  (buf_full)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      instr_d   = instr_q;
      reqcyc_d  = reqcyc_q;
      req_d     = req_q;
      reqtag_d  = reqtag_q;
      respack_d = fill_if.bus_respcyc;
      buf_clr   = 1'b0;
      case (state_q)
         S_IDLE: if (fill_if.miss_valid) begin
            state_d  = S_REQ;
            addr_d   = line_align(fill_if.miss_addr);
            instr_d  = fill_if.miss_instr;
            reqcyc_d = 1'b1;
            req_d    = BUS_DW'(line_align(fill_if.miss_addr));
            reqtag_d = MEM_READ_TAG;
            buf_clr  = 1'b1;
         end
         S_REQ: if (fill_if.bus_reqack) begin
            state_d  = S_RESP;
            reqcyc_d = 1'b0;
            req_d    = '0;
            reqtag_d = '0;
         end
         S_RESP: if (buf_full) state_d = S_DONE;
         S_DONE: if (fill_if.fill_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (timeout) begin
         state_d  = S_IDLE;
         reqcyc_d = 1'b0;
         req_d    = '0;
         reqtag_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         instr_q   <= 1'b0;
         reqcyc_q  <= 1'b0;
         req_q     <= '0;
         reqtag_q  <= '0;
         respack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         instr_q   <= instr_d;
         reqcyc_q  <= reqcyc_d;
         req_q     <= req_d;
         reqtag_q  <= reqtag_d;
         respack_q <= respack_d;
      end
   end

`ifdef CACHE_FILL_TIMEOUT_EN
   logic [15:0] wdog_q, wdog_d;
   logic        fill_error_q;
   logic        busy, handshake;

   assign busy      = (state_q == S_REQ) || (state_q == S_RESP);
   assign handshake = ((state_q == S_REQ) && fill_if.bus_reqack) || beat_ok;

   // Fires on the edge that ends the TIMEOUT_CYCLES-th idle-handshake cycle.
   always_comb begin
      timeout = 1'b0;
      wdog_d  = '0;
      if (busy && !handshake) begin
         if (wdog_q == 16'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
         else                                   wdog_d  = wdog_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdog_q       <= '0;
         fill_error_q <= 1'b0;
      end else begin
         wdog_q       <= wdog_d;
         fill_error_q <= timeout;
      end
   end

   assign fill_if.fill_error = fill_error_q;
`else
   assign timeout            = 1'b0;
   assign fill_if.fill_error = 1'b0;
`endif

   assign fill_if.miss_ready  = (state_q == S_IDLE);
   assign fill_if.fill_valid  = (state_q == S_DONE);
   assign fill_if.fill_addr   = addr_q;
   assign fill_if.fill_instr  = instr_q;
   assign fill_if.fill_line   = line;
   assign fill_if.bus_reqcyc  = reqcyc_q;
   assign fill_if.bus_req     = req_q;
   assign fill_if.bus_reqtag  = reqtag_q;
   assign fill_if.bus_respack = respack_q;
endmodule

// File: tb/tb_cache_line_fill.sv
// Bench for cache_line_fill: table of fill scenarios with a fill scoreboard, plus reset-abort and
// watchdog sequences; every negedge also checks bus_respack against the previous edge's bus_respcyc.
module tb_cache_line_fill;
   import cache_line_fill_pkg::*;

   typedef struct {
      logic [63:0] addr;
      logic        instr;
      logic [63:0] base;
      int          ack_dly;
      int          gap;
      int          bad_slot;
      bit          ack_beat;
      int          rdy_dly;
      bit          hold_miss;
      logic [63:0] exp_addr;
      int          exp_lat;
      int          exp_acks;
   } vec_t;

   typedef struct {
      logic [63:0] addr;
      logic        instr;
      cache_line_t line;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks    = 0;
   int   errors    = 0;
   int   ack_total = 0;
   exp_t sb[$];
   vec_t vecs[6];

   always #5 clk = ~clk;

   cache_line_fill_if fi ();

   cache_line_fill #(.TIMEOUT_CYCLES(16)) dut (
      .clk     (clk),
      .reset   (rst_n),
      .fill_if (fi)
   );

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      logic ack_exp;
      ack_exp = rst_n && fi.bus_respcyc;
      @(negedge clk);
      chk("respack", fi.bus_respack, ack_exp);
      if (fi.bus_respack) ack_total++;
`ifndef CACHE_FILL_TIMEOUT_EN
      chk("fill_error_idle", fi.fill_error, 1'b0);
`endif
   endtask

   task automatic drive_idle();
      fi.miss_valid  = 1'b0;
      fi.miss_addr   = '0;
      fi.miss_instr  = 1'b0;
      fi.fill_ready  = 1'b0;
      fi.bus_reqack  = 1'b0;
      fi.bus_respcyc = 1'b0;
      fi.bus_resp    = '0;
      fi.bus_resptag = '0;
   endtask

   task automatic beat(input logic [63:0] d, input logic [TAG_W-1:0] tag);
      fi.bus_respcyc = 1'b1;
      fi.bus_resp    = d;
      fi.bus_resptag = tag;
      tick();
      fi.bus_respcyc = 1'b0;
      fi.bus_resp    = '0;
      fi.bus_resptag = '0;
   endtask

   task automatic chk_reset();
      chk("rst_miss_ready", fi.miss_ready, 1'b1);
      chk("rst_fill_valid", fi.fill_valid, 1'b0);
      chk("rst_fill_addr", fi.fill_addr, '0);
      chk("rst_fill_instr", fi.fill_instr, 1'b0);
      chk("rst_fill_line", fi.fill_line, '0);
      chk("rst_fill_error", fi.fill_error, 1'b0);
      chk("rst_reqcyc", fi.bus_reqcyc, 1'b0);
      chk("rst_req", fi.bus_req, '0);
      chk("rst_reqtag", fi.bus_reqtag, '0);
      chk("rst_respack", fi.bus_respack, 1'b0);
   endtask

   task automatic run_fill(input vec_t v);
      exp_t        e;
      exp_t        got;
      cache_line_t held;
      int          t;
      int          ack0;
      logic [TAG_W-1:0] bad_tag;
      bad_tag = ~MEM_READ_TAG;
      for (int s = 0; s < BEATS; s++) e.line[s] = v.base + 64'(s);
      e.addr  = v.exp_addr;
      e.instr = v.instr;
      sb.push_back(e);
      ack0 = ack_total;

      chk("miss_ready_idle", fi.miss_ready, 1'b1);
      fi.miss_valid = 1'b1;
      fi.miss_addr  = v.addr;
      fi.miss_instr = v.instr;
      tick();
      t = 1;
      fi.miss_valid = 1'b0;
      fi.miss_addr  = '1;
      fi.miss_instr = ~v.instr;
      chk("reqcyc", fi.bus_reqcyc, 1'b1);
      chk("req_addr", fi.bus_req, v.exp_addr);
      chk("reqtag", fi.bus_reqtag, MEM_READ_TAG);
      chk("miss_ready_busy", fi.miss_ready, 1'b0);
      chk("line_cleared", fi.fill_line, '0);

      for (int i = 0; i < v.ack_dly; i++) begin
         tick();
         t++;
         chk("req_hold", {fi.bus_reqcyc, fi.bus_reqtag, fi.bus_req}, {1'b1, MEM_READ_TAG, v.exp_addr});
      end
      fi.bus_reqack = 1'b1;
      if (v.ack_beat) begin
         fi.bus_respcyc = 1'b1;
         fi.bus_resp    = 64'hFEED_FEED;
         fi.bus_resptag = MEM_READ_TAG;
      end
      tick();
      t++;
      fi.bus_reqack  = 1'b0;
      fi.bus_respcyc = 1'b0;
      fi.bus_resp    = '0;
      fi.bus_resptag = '0;
      chk("req_cleared", {fi.bus_reqcyc, fi.bus_reqtag, fi.bus_req}, '0);

      for (int s = 0; s < BEATS; s++) begin
         chk("no_early_fill", fi.fill_valid, 1'b0);
         if (s == v.bad_slot) begin
            beat(64'hBAD0 + 64'(s), bad_tag);
            t++;
            for (int g = 0; g < v.gap; g++) begin tick(); t++; end
         end
         beat(e.line[s], MEM_READ_TAG);
         t++;
         if (s != BEATS - 1)
            for (int g = 0; g < v.gap; g++) begin tick(); t++; end
      end
      while (!fi.fill_valid && t < 200) begin tick(); t++; end
      chk("fill_latency", t, v.exp_lat);
      if (!fi.fill_valid) begin
         rst_n = 1'b0;
         drive_idle();
         tick();
         rst_n = 1'b1;
         tick();
         sb.delete();
         return;
      end

      for (int i = 0; i < v.rdy_dly; i++) begin
         if (v.hold_miss) begin
            fi.miss_valid = 1'b1;
            fi.miss_addr  = 64'h5000;
         end
         held = fi.fill_line;
         tick();
         chk("line_held", fi.fill_line, held);
         chk("fill_valid_held", fi.fill_valid, 1'b1);
         chk("miss_ready_stall", fi.miss_ready, 1'b0);
      end
      got = sb.pop_front();
      chk("fill_addr", fi.fill_addr, got.addr);
      chk("fill_instr", fi.fill_instr, got.instr);
      chk("fill_line", fi.fill_line, got.line);
      fi.fill_ready = 1'b1;
      tick();
      fi.fill_ready = 1'b0;
      chk("fill_valid_drop", fi.fill_valid, 1'b0);
      chk("miss_ready_after", fi.miss_ready, 1'b1);
      chk("no_miss_on_accept", fi.bus_reqcyc, 1'b0);
      fi.miss_valid = 1'b0;
      chk("respack_count", ack_total - ack0, v.exp_acks);
   endtask

   initial begin
      //         addr                    ins base                    ack gap bad ab rdy hm exp_addr                lat acks
      vecs[0] = '{64'h0000_0000_1234_5678, 1'b0, 64'h100,                0, 0, -1, 0, 0, 0, 64'h0000_0000_1234_5640, 10, 8};
      vecs[1] = '{64'hFFFF_0000_0000_107F, 1'b1, 64'hA000_0000_0000_0000, 5, 2, -1, 0, 0, 0, 64'hFFFF_0000_0000_1040, 29, 8};
      vecs[2] = '{64'h0000_0000_8000_003F, 1'b0, 64'h5555_5555_0000_0000, 0, 0, -1, 0, 4, 1, 64'h0000_0000_8000_0000, 10, 8};
      vecs[3] = '{64'h0000_0000_0000_0040, 1'b1, 64'h7700,               0, 0,  3, 0, 0, 0, 64'h0000_0000_0000_0040, 11, 9};
      vecs[4] = '{64'hDEAD_BEEF_CAFE_0001, 1'b0, 64'h0123_4567_89AB_0000, 2, 0, -1, 1, 1, 0, 64'hDEAD_BEEF_CAFE_0000, 12, 9};
      vecs[5] = '{64'h0000_0000_1000_00C0, 1'b1, 64'h900,                0, 0, -1, 0, 0, 0, 64'h0000_0000_1000_00C0, 10, 8};

      drive_idle();
      #1;
      chk_reset();
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) run_fill(vecs[i]);

      // Abort after four beats, then a stray beat in IDLE, then a clean fill.
      fi.miss_valid = 1'b1;
      fi.miss_addr  = 64'h2000;
      fi.miss_instr = 1'b1;
      tick();
      fi.miss_valid = 1'b0;
      fi.bus_reqack = 1'b1;
      tick();
      fi.bus_reqack = 1'b0;
      for (int s = 0; s < 4; s++) beat(64'hDEAD_0000 + 64'(s), MEM_READ_TAG);
      rst_n = 1'b0;
      #1;
      chk_reset();
      tick();
      rst_n = 1'b1;
      tick();
      beat(64'h5757, MEM_READ_TAG);
      tick();
      chk("stray_beat_idle", {fi.fill_valid, fi.miss_ready, fi.bus_reqcyc}, 3'b010);
      run_fill(vecs[5]);

`ifdef CACHE_FILL_TIMEOUT_EN
      begin
         int t;
         fi.miss_valid = 1'b1;
         fi.miss_addr  = 64'h3000;
         tick();
         fi.miss_valid = 1'b0;
         t = 1;
         while (!fi.fill_error && t < 100) begin tick(); t++; end
         chk("timeout_cycles", t - 1, 16);
         chk("timeout_reqcyc", fi.bus_reqcyc, 1'b0);
         chk("timeout_miss_ready", fi.miss_ready, 1'b1);
         chk("timeout_no_fill", fi.fill_valid, 1'b0);
         tick();
         chk("timeout_pulse", fi.fill_error, 1'b0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cache_line_fill.md
# cache_line_fill

Line-fill engine between the L1 cache and the memory bus. It accepts one miss request (instruction or data) from the cache and issues a single 64-byte-aligned `MEM_READ` on the bus request channel. It then collects eight 64-bit response beats into one 512-bit line and hands the completed line back to the cache for insertion. Only one fill is outstanding at a time; the cache stalls its requesters while `miss_ready` is low.

## Interface
- `BEATS`, 8: response beats per line; equals `CELLS_NEEDED`, 64 B / 8 B.
- `TIMEOUT_CYCLES`, 1024: watchdog limit, used only with `CACHE_FILL_TIMEOUT_EN`.
- One clock; reset is asynchronous and active-low.
- `clk`, in, 1: sole clock; everything samples on its rising edge.
- `reset`, in, 1: asynchronous, active-low; forces IDLE and the output reset values below.
- `miss_valid`, in, 1: cache presents a miss.
- `miss_ready`, out, 1: engine can accept a miss; high only in IDLE.
- `miss_addr`, in, `ADDRESS_SIZE`: byte address of the miss.
- `miss_instr`, in, 1: 1 = instruction cache miss, 0 = data cache miss.
- `fill_valid`, out, 1: completed line available.
- `fill_ready`, in, 1: cache accepts the line.
- `fill_addr`, out, `ADDRESS_SIZE`: line-aligned address; bits [5:0] are 0.
- `fill_instr`, out, 1: echo of `miss_instr`.
- `fill_line`, out, `BUS_DATA_WIDTH*BEATS`: beat *n* occupies bits [64n+63:64n].
- `fill_error`, out, 1: one-cycle timeout pulse; tied 0 without the macro.
- `bus_reqcyc`, out, 1: request valid.
- `bus_reqack`, in, 1: request accepted.
- `bus_req`, out, `BUS_DATA_WIDTH`: request address.
- `bus_reqtag`, out, `BUS_TAG_WIDTH`: request tag.
- `bus_respcyc`, in, 1: response beat valid.
- `bus_respack`, out, 1: response beat acknowledge.
- `bus_resp`, in, `BUS_DATA_WIDTH`: response data.
- `bus_resptag`, in, `BUS_TAG_WIDTH`: response tag.

## Operation
- FSM states and transitions:
  - IDLE: `miss_valid && miss_ready` → REQ.
  - REQ: `bus_reqack` → RESP.
  - RESP: eighth accepted beat → DONE.
  - DONE: `fill_ready` → IDLE.
- Miss capture:
  - On the accepting edge, register `miss_addr & ~64'h3F` and `miss_instr`.
  - `miss_addr` is ignored in every other state.
- REQ state:
  - Drive `bus_reqcyc`=1, `bus_req`=aligned address, `bus_reqtag`=`MEM_READ`.
  - Hold all three stable until `bus_reqack` is sampled high.
  - On that edge, clear all three to 0.
- RESP state:
  - A beat is accepted on each edge where `bus_respcyc`=1 and `bus_resptag`=`MEM_READ`.
  - Each accepted beat is written to slot `beat_cnt`; `beat_cnt` (3-bit) increments and wraps 7→0 on the eighth beat.
  - `bus_respack` is registered: high for exactly the one cycle after each beat with `bus_respcyc`=1, including beats with a wrong tag.
  - Wrong-tag beats are acked but dropped; `beat_cnt` does not increment.
- DONE state:
  - `fill_valid`=1; `fill_line`, `fill_addr` and `fill_instr` are stable until the `fill_ready` edge.
  - `fill_valid` falls on the edge after acceptance.
- Outside RESP, `bus_respcyc` still causes a `bus_respack` pulse, but the data is discarded (stray beats).
- The line buffer clears to 0 on entry to REQ, so a partial line from an aborted fill never leaks.

## Timing
- Reset values: all outputs 0 except `miss_ready`=1; state IDLE; `beat_cnt`=0; line buffer 0.
- Reset mid-fill: immediate return to IDLE. The cache must reissue the miss; bus beats of the aborted fill arriving later are acked as stray.
- Minimum miss-to-fill latency, counting the miss-accept edge as E0:
  - `bus_reqcyc` is high in E0–E1.
  - Ack at E1.
  - Beats at E2–E9.
  - `fill_valid` is high after E9, i.e. 10 cycles.
- Simultaneous events:
  - `fill_ready` in DONE together with `miss_valid`: the line is accepted, but the new miss is not; `miss_ready` becomes 1 only the cycle after.
  - `bus_reqack` and `bus_respcyc` on the same edge in REQ: the beat is acked but not counted.

## Configuration
- `CACHE_FILL_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts cycles spent in REQ or RESP and resets on every accepted handshake.
  - When it reaches `TIMEOUT_CYCLES`: pulse `fill_error` for 1 cycle, drop `bus_reqcyc`, go to IDLE, and do not assert `fill_valid`.
- Undefined: no counter; `fill_error` is constant 0; the engine waits forever.

## Structure
- Shared package holds:
  - `fill_state_t` (IDLE/REQ/RESP/DONE).
  - `cache_line_t`, 512-bit packed array of `BEATS` 64-bit cells, shared with the cache's `cache_cells`.
  - `LINE_OFFSET_MASK` = 64'h3F.
  - `MEM_READ` and bus widths continue to come from the existing global defines.
- One natural sub-module: `fill_line_buffer`, which holds the beat counter and the indexed write into `cache_line_t`, with clear, write and full outputs.

## Test plan
- Basic fill:
  - Stimulus: miss at 0x1234_5678; immediate ack; beats 0x100..0x107 back-to-back.
  - Required: `bus_req`=0x1234_5640; `fill_valid` after 10 cycles; slot 0=0x100, slot 7=0x107; `fill_addr`=0x1234_5640.
- Stalled ack and gapped beats:
  - Stimulus: ack after 5 cycles; beats with 2-cycle gaps.
  - Required: `bus_req` held stable; exactly 8 `bus_respack` pulses; line correct.
- Backpressure:
  - Stimulus: `fill_ready` low for 4 cycles, with a new `miss_valid` present.
  - Required: `fill_line` held; `miss_ready`=0 until the cycle after acceptance.
- Wrong tag:
  - Stimulus: beat 3 carries a non-`MEM_READ` tag.
  - Required: it is acked; the next `MEM_READ` beat fills slot 3; the fill needs 9 beats.
- Reset at beat 4:
  - Required: all outputs at reset values and IDLE.
  - Follow-up: a new miss fills cleanly, with no data from the old buffer in the line.
- Timeout, with `CACHE_FILL_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16:
  - Stimulus: no ack.
  - Required: `fill_error` pulses after 16 cycles; `bus_reqcyc` returns to 0; `miss_ready`=1.
